// File: rtl/adder_arbiter.sv
// -----------------------------------------------------------------------------
// adder_arbiter
//   Shares one WIDTH-bit unsigned adder between NUM_REQ = 2**ID_W requesters.
//   A request is granted in IDLE and its operands are captured. The sum is
//   computed in CALC. The (WIDTH+1)-bit result, tagged with the requester
//   index, is held in HOLD until the consumer accepts it.
//
//   Build option:
//     ADDER_ARBITER_FIXED_PRIO_EN - when defined, the lowest valid index always
//     wins and no round-robin pointer exists. When undefined (default), the
//     scan starts at the requester after the last one served.
//
//   Ports:
//     clk        in   system clock, rising edge
//     rst        in   synchronous active-high reset
//     req_valid  in   [NUM_REQ]        per-requester request valid
//     req_ready  out  [NUM_REQ]        one-hot grant/accept strobe (IDLE only)
//     req_a      in   [NUM_REQ*WIDTH]  operand A, requester i at [i*WIDTH +: WIDTH]
//     req_b      in   [NUM_REQ*WIDTH]  operand B, same packing
//     res_valid  out  result valid
//     res_ready  in   consumer accepts the result
//     res_sum    out  [WIDTH+1]        registered sum
//     res_id     out  [ID_W]           index of the requester that produced res_sum
// -----------------------------------------------------------------------------
module adder_arbiter #(
  parameter int ID_W  = 2,
  parameter int WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [(2**ID_W)-1:0]        req_valid,
  output logic [(2**ID_W)-1:0]        req_ready,
  input  logic [(2**ID_W)*WIDTH-1:0]  req_a,
  input  logic [(2**ID_W)*WIDTH-1:0]  req_b,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [WIDTH:0]              res_sum,
  output logic [ID_W-1:0]             res_id
);

  localparam int NUM_REQ = 2**ID_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [ID_W-1:0]      g_q, g_d;
  logic                 res_valid_q, res_valid_d;
  logic [WIDTH:0]       res_sum_q, res_sum_d;
  logic [ID_W-1:0]      res_id_q, res_id_d;

  logic [NUM_REQ-1:0]   req_ready_s;
  logic [ID_W-1:0]      scan_base_s;
  logic [ID_W-1:0]      cand_s;
  logic [ID_W-1:0]      grant_s;
  logic                 found_s;
  logic                 hit_s;

`ifdef ADDER_ARBITER_FIXED_PRIO_EN
  // Fixed priority: the scan always starts at requester 0.
  assign scan_base_s = {ID_W{1'b0}};
`else
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;

  // Round-robin pointer moves past the requester whose result was just accepted.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == HOLD && res_ready) begin
      rr_ptr_d = res_id_q + ID_W'(1'b1);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= {ID_W{1'b0}};
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign scan_base_s = rr_ptr_q;
`endif

  // Grant search: the scan runs from the farthest offset down to the nearest,
  // so the valid requester closest to scan_base_s is the last one written.
  always_comb begin
    grant_s = {ID_W{1'b0}};
    found_s = 1'b0;
    cand_s  = {ID_W{1'b0}};
    hit_s   = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand_s  = scan_base_s + ID_W'(k);
      hit_s   = req_valid[cand_s];
      grant_s = hit_s ? cand_s : grant_s;
      found_s = found_s | hit_s;
    end
  end

  // FSM next state, grant strobe and datapath updates.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    g_d         = g_q;
    res_valid_d = res_valid_q;
    res_sum_d   = res_sum_q;
    res_id_d    = res_id_q;
    req_ready_s = {NUM_REQ{1'b0}};
    case (state_q)
      IDLE: begin
        // The grant is gated by rst so that req_ready stays low during reset.
        // The granted bit is valid by construction, so the handshake
        // completes on the next edge.
        if (found_s && !rst) begin
          req_ready_s[grant_s] = 1'b1;
          a_d     = req_a[int'(grant_s)*WIDTH +: WIDTH];
          b_d     = req_b[int'(grant_s)*WIDTH +: WIDTH];
          g_d     = grant_s;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        res_sum_d   = {1'b0, a_q} + {1'b0, b_q};
        res_id_d    = g_q;
        res_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d     = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      g_q         <= {ID_W{1'b0}};
      res_valid_q <= 1'b0;
      res_sum_q   <= {(WIDTH+1){1'b0}};
      res_id_q    <= {ID_W{1'b0}};
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      g_q         <= g_d;
      res_valid_q <= res_valid_d;
      res_sum_q   <= res_sum_d;
      res_id_q    <= res_id_d;
    end
  end

  assign req_ready = req_ready_s;
  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_id    = res_id_q;

endmodule

// File: tb/tb_adder_arbiter.sv
module tb_adder_arbiter;

  localparam int ID_W  = 2;
  localparam int WIDTH = 4;
  localparam int N     = 4;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [15:0]   req_a;
  logic [15:0]   req_b;
  logic          res_valid;
  logic          res_ready;
  logic [4:0]    res_sum;
  logic [1:0]    res_id;

  int n_checks;
  int n_errors;
  int model_ptr;
  logic [3:0] a_arr [N];
  logic [3:0] b_arr [N];

  adder_arbiter #(.ID_W(ID_W), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_id    (res_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arbitration: first valid requester scanning from the pointer.
  function automatic int exp_grant(input logic [N-1:0] v);
    int base;
`ifdef ADDER_ARBITER_FIXED_PRIO_EN
    base = 0;
`else
    base = model_ptr;
`endif
    for (int k = 0; k < N; k++) begin
      if (v[(base + k) % N]) return (base + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int idx);
    logic [N-1:0] r;
    r = '0;
    if (idx >= 0) r[idx] = 1'b1;
    return r;
  endfunction

  task automatic put_ops();
    for (int i = 0; i < N; i++) begin
      req_a[i*4 +: 4] = a_arr[i];
      req_b[i*4 +: 4] = b_arr[i];
    end
  endtask

  task automatic scramble();
    req_a = 16'($urandom);
    req_b = 16'($urandom);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = 4'($urandom);
    scramble();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    req_valid = 4'b0000;
    model_ptr = 0;
  endtask

  // One full transaction with res_ready high; fixed_ops forces every
  // requester's operands to fa/fb. Returns the observed res_id.
  task automatic run_txn(input logic [N-1:0] v, input bit fixed_ops,
                         input int fa, input int fb, output int obs_id);
    int g;
    logic [4:0] exp_sum;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      a_arr[i] = fixed_ops ? 4'(fa) : 4'($urandom_range(0, 15));
      b_arr[i] = fixed_ops ? 4'(fb) : 4'($urandom_range(0, 15));
    end
    put_ops();
    req_valid = v;
    res_ready = 1'b1;
    #1;
    g = exp_grant(v);
    exp_sum = 5'(int'(a_arr[g]) + int'(b_arr[g]));
    n_checks++;
    if (req_ready !== onehot(g)) begin
      n_errors++;
      $display("FAIL grant: req_ready=%b expected %b (valid=%b)", req_ready, onehot(g), v);
    end
    @(negedge clk);
    scramble();
    req_valid = 4'($urandom);
    #1;
    n_checks++;
    if (req_ready !== 4'b0000 || res_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL calc_state: req_ready=%b res_valid=%b expected 0000/0", req_ready, res_valid);
    end
    @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b1 || res_sum !== exp_sum || res_id !== 2'(g) || req_ready !== 4'b0000) begin
      n_errors++;
      $display("FAIL result: valid=%b sum=%0d id=%0d ready=%b expected 1/%0d/%0d/0000",
               res_valid, res_sum, res_id, req_ready, exp_sum, g);
    end
    obs_id = int'(res_id);
    model_ptr = (g + 1) % N;
    req_valid = 4'b0000;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      req_valid = 4'($urandom_range(1, 15));
      res_ready = 1'($urandom);
      scramble();
      #1;
      n_checks++;
      if (res_valid !== 1'b0 || res_sum !== 5'd0 || res_id !== 2'd0 || req_ready !== 4'b0000) begin
        n_errors++;
        $display("FAIL reset: valid=%b sum=%0d id=%0d ready=%b expected all zero",
                 res_valid, res_sum, res_id, req_ready);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    req_valid = 4'b0000;
    model_ptr = 0;
  endtask

  task automatic test_single();
    int id;
    @(negedge clk);
    // a0=2, b0=3 -> 5 from requester 0
    run_txn(4'b0001, 1'b1, 2, 3, id);
    n_checks++;
    if (res_sum !== 5'd5 || id != 0) begin
      n_errors++;
      $display("FAIL single: sum=%0d id=%0d expected 5/0", res_sum, id);
    end
  endtask

  task automatic test_corners();
    int ca [4] = '{15, 15, 0, 9};
    int cb [4] = '{15, 1, 0, 6};
    int ce [4] = '{30, 16, 0, 15};
    int id;
    for (int i = 0; i < 4; i++) begin
      run_txn(onehot(3 - i), 1'b1, ca[i], cb[i], id);
      n_checks++;
      if (res_sum !== 5'(ce[i]) || id != 3 - i) begin
        n_errors++;
        $display("FAIL corner_%0d: sum=%0d id=%0d expected %0d/%0d", i, res_sum, id, ce[i], 3 - i);
      end
    end
  endtask

  task automatic test_round_robin();
`ifdef ADDER_ARBITER_FIXED_PRIO_EN
    int order [6] = '{0, 0, 0, 0, 0, 0};
`else
    int order [6] = '{0, 1, 2, 3, 0, 1};
`endif
    int id;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      run_txn(4'b1111, 1'b0, 0, 0, id);
      n_checks++;
      if (id != order[i]) begin
        n_errors++;
        $display("FAIL rr_order_%0d: id=%0d expected %0d", i, id, order[i]);
      end
    end
  endtask

  task automatic test_random();
    int id;
    for (int i = 0; i < 30; i++) begin
      run_txn(4'($urandom_range(1, 15)), 1'b0, 0, 0, id);
    end
  endtask

  task automatic test_back_to_back();
    int g;
    logic [4:0] exp_sum;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      a_arr[i] = 4'($urandom_range(0, 15));
      b_arr[i] = 4'($urandom_range(0, 15));
    end
    put_ops();
    req_valid = 4'b0100;
    res_ready = 1'b0;
    g = exp_grant(4'b0100);
    exp_sum = 5'(int'(a_arr[g]) + int'(b_arr[g]));
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b1 || res_sum !== exp_sum || res_id !== 2'(g)) begin
      n_errors++;
      $display("FAIL bp_result: valid=%b sum=%0d id=%0d expected 1/%0d/%0d", res_valid, res_sum, res_id, exp_sum, g);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      scramble();
      req_valid = 4'($urandom_range(1, 15));
      #1;
      n_checks++;
      if (res_valid !== 1'b1 || res_sum !== exp_sum || res_id !== 2'(g) || req_ready !== 4'b0000) begin
        n_errors++;
        $display("FAIL bp_hold_%0d: valid=%b sum=%0d id=%0d ready=%b expected 1/%0d/%0d/0000",
                 c, res_valid, res_sum, res_id, req_ready, exp_sum, g);
      end
    end
    res_ready = 1'b1;
    model_ptr = (g + 1) % N;
    @(negedge clk);
    res_ready = 1'b0;
    req_valid = 4'b1111;
    #1;
    n_checks++;
    if (res_valid !== 1'b0 || req_ready !== onehot(exp_grant(4'b1111))) begin
      n_errors++;
      $display("FAIL bp_release: valid=%b ready=%b expected 0/%b", res_valid, req_ready, onehot(exp_grant(4'b1111)));
    end
    req_valid = 4'b0000;
  endtask

  // Reset during CALC (in_hold=0) or HOLD (in_hold=1).
  task automatic test_reset_mid(input bit in_hold);
    @(negedge clk);
    req_valid = 4'b0010;
    res_ready = 1'b0;
    scramble();
    @(negedge clk);
    req_valid = 4'b0000;
    if (in_hold) begin
      @(negedge clk);
      n_checks++;
      if (res_valid !== 1'b1) begin
        n_errors++;
        $display("FAIL mid_pre_%0d: res_valid=%b expected 1", in_hold, res_valid);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    #1;
    n_checks++;
    if (res_valid !== 1'b0 || res_sum !== 5'd0 || res_id !== 2'd0 || req_ready !== 4'b0000) begin
      n_errors++;
      $display("FAIL mid_rst_%0d: valid=%b sum=%0d id=%0d ready=%b expected zeros",
               in_hold, res_valid, res_sum, res_id, req_ready);
    end
    rst = 1'b0;
    res_ready = 1'b1;
    model_ptr = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (res_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL mid_stale_%0d_%0d: res_valid=%b expected 0", in_hold, c, res_valid);
      end
    end
    req_valid = 4'b1111;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_errors++;
      $display("FAIL mid_first_grant_%0d: req_ready=%b expected 0001", in_hold, req_ready);
    end
    req_valid = 4'b0000;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    model_ptr = 0;
    rst       = 1'b1;
    req_valid = 4'b0000;
    req_a     = 16'h0000;
    req_b     = 16'h0000;
    res_ready = 1'b0;
    test_reset();
    test_single();
    test_corners();
    test_round_robin();
    test_random();
    test_back_to_back();
    test_reset_mid(1'b0);
    test_reset_mid(1'b1);
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
